int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of external interrupt channels, legal range 1..15.
REQ-002 SHALL have parameter TMR_W, default 32, timer counter and limit width.
REQ-003 SHALL have parameter EDGE_MASK, N_IRQ bits, default all-0; bit k=1 makes channel k edge-triggered, 0 makes it level-triggered.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port irq_i  input  N_IRQ  external interrupt lines.
REQ-007 SHALL have port en_i  input  N_IRQ  per-channel enable mask (mie).
REQ-008 SHALL have port gie_i  input  1  global interrupt enable (mstatus.MIE).
REQ-009 SHALL have port nmi_i  input  1  non-maskable interrupt line, rising-edge sensitive.
REQ-010 SHALL have port en_tmr_i  input  1  timer count enable.
REQ-011 SHALL have port tmr_limit_i  input  TMR_W  timer compare value.
REQ-012 SHALL have port tmr_clr_i  input  1  synchronous timer counter clear.
REQ-013 SHALL have port ack_i  input  1  core accepts the presented trap this cycle.
REQ-014 SHALL have port mret_i  input  1  core executes MRET (handler complete).
REQ-015 SHALL have port req_o  output  1  trap request to core.
REQ-016 SHALL have port cause_o  output  5  cause code of presented trap.
REQ-017 SHALL have port nmi_o  output  1  presented/active trap is NMI.
REQ-018 SHALL have port busy_o  output  1  a handler is in service.
REQ-019 SHALL have port pending_o  output  N_IRQ  registered pending bits.
REQ-020 SHALL have port tmr_cnt_o  output  TMR_W  timer counter value.

Function
REQ-021 SHALL register pending: level channel k pend[k] <= irq_i[k] every cycle; edge channel k sets pend[k] on registered rising edge, clears on ack of cause 16+k; set wins over simultaneous clear.
REQ-022 SHALL latch NMI rising edge into nmi_pend; clear on NMI ack; set wins over clear.
REQ-023 SHALL run timer: tmr_clr_i -> cnt=0 (highest priority); else tmr_limit_i==0 -> cnt held 0, no pend; else en_tmr_i and cnt==tmr_limit_i -> cnt=0, tmr_pend=1; else en_tmr_i -> cnt+1; timer pend cleared only on timer ack.
REQ-024 SHALL encode causes: NMI=31, timer=7, ext channel k=16+k.
REQ-025 SHALL prioritise NMI > timer > ext channel lowest index first; maskable sources qualified by gie_i and (en_i[k] or en_tmr_i for timer).
REQ-026 SHALL implement FSM IDLE/REQ/SERVICE plus nmi_active flag.
REQ-027 IDLE: any qualified source -> REQ, latching winning cause into cause_o and nmi_o.
REQ-028 REQ: req_o=1, cause_o/nmi_o frozen regardless of new arrivals or gie_i change; ack_i -> SERVICE, clear the acked source's pend.
REQ-029 SERVICE: busy_o=1; maskable sources ignored; nmi_pend with nmi_active=0 -> REQ with cause 31 (single-level NMI preemption); mret_i -> IDLE, or back to SERVICE of the preempted handler if returning from a preempting NMI (one-deep saved cause).
REQ-030 SHALL set nmi_active on NMI ack, clear on the matching mret_i.
REQ-031 SHALL ignore ack_i outside REQ and mret_i outside SERVICE.
REQ-032 Latency: irq_i rising before edge t -> pend at t -> req_o high after edge t+1.
REQ-033 SHALL never deassert req_o in REQ except by ack_i or reset.

Reset
REQ-034 rst low SHALL immediately clear FSM to IDLE, cnt, all pend bits, nmi_active, saved cause; req_o=0, cause_o=0, nmi_o=0, busy_o=0, pending_o=0, tmr_cnt_o=0.
REQ-035 Reset mid-REQ or mid-SERVICE SHALL drop the request with no ack required; first post-reset request follows REQ-032 latency.

Verification
REQ-036 gie=1, en_i=0xFF, irq_i=0x24 level -> req_o after 2 edges, cause_o=18; ack -> busy_o=1; mret -> IDLE, re-request cause 18 if line held.
REQ-037 tmr_limit_i=3, en_tmr_i=1 -> cnt 0,1,2,3,0; tmr_pend at wrap; cause_o=7; limit=0 -> cnt stays 0, no request.
REQ-038 Timer and irq_i[0] pending together -> cause 7 first; irq 0 (cause 16) presented after mret.
REQ-039 Channel 2 edge-triggered in SERVICE of cause 16, nmi_i pulse -> REQ cause 31, nmi_o=1; ack; mret -> SERVICE cause 16; mret -> IDLE; pulse on ch2 during all this still pending (cause 18 next).
REQ-040 gie_i=0 -> no maskable request; NMI still requested; gie_i dropped during REQ -> req_o held until ack.
REQ-041 Assert rst low during REQ -> all outputs 0 asynchronously, before next clock edge.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: prioritised NMI, timer and external channels.
// One-deep NMI preemption of a running handler.
module int_ctrl #(
  parameter int               N_IRQ     = 8,
  parameter int               TMR_W     = 32,
  parameter logic [N_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] en_i,
  input  logic             gie_i,
  input  logic             nmi_i,
  input  logic             en_tmr_i,
  input  logic [TMR_W-1:0] tmr_limit_i,
  input  logic             tmr_clr_i,
  input  logic             ack_i,
  input  logic             mret_i,
  output logic             req_o,
  output logic [4:0]       cause_o,
  output logic             nmi_o,
  output logic             busy_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic [TMR_W-1:0] tmr_cnt_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [4:0] CAUSE_NMI = 5'd31;
  localparam logic [4:0] CAUSE_TMR = 5'd7;

  logic [1:0]       state;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] pend;
  logic             nmi_prev;
  logic             nmi_pend;
  logic             tmr_pend;
  logic [TMR_W-1:0] cnt;
  logic [4:0]       cause_q;
  logic             nmi_q;
  logic             nmi_active;
  logic [4:0]       saved_cause;
  logic             saved_valid;

  logic             ack_fire;
  logic             tmr_wrap;
  logic [N_IRQ-1:0] ext_q;
  logic             win_valid;
  logic [4:0]       win_cause;
  logic             win_nmi;

  assign ack_fire = (state == ST_REQ) && ack_i;
  assign tmr_wrap = !tmr_clr_i && (tmr_limit_i != '0) && en_tmr_i && (cnt == tmr_limit_i);
  assign ext_q    = pend & en_i & {N_IRQ{gie_i}};

  // Level channels mirror the line; edge channels latch a rise until acked.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      irq_prev <= '0;
      pend     <= '0;
    end else begin
      irq_prev <= irq_i;
      for (int k = 0; k < N_IRQ; k++) begin
        if (EDGE_MASK[k]) begin
          if (irq_i[k] && !irq_prev[k])
            pend[k] <= 1'b1;
          else if (ack_fire && (cause_q == 5'(16 + k)))
            pend[k] <= 1'b0;
        end else begin
          pend[k] <= irq_i[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_i;
      if (nmi_i && !nmi_prev)
        nmi_pend <= 1'b1;
      else if (ack_fire && (cause_q == CAUSE_NMI))
        nmi_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      tmr_pend <= 1'b0;
    end else begin
      if (tmr_clr_i)
        cnt <= '0;
      else if (tmr_limit_i == '0)
        cnt <= '0;
      else if (tmr_wrap)
        cnt <= '0;
      else if (en_tmr_i)
        cnt <= cnt + TMR_W'(1);

      if (tmr_wrap)
        tmr_pend <= 1'b1;
      else if (ack_fire && (cause_q == CAUSE_TMR))
        tmr_pend <= 1'b0;
    end
  end

  // Descending scan so the lowest-index qualified channel wins.
  always_comb begin
    win_valid = 1'b0;
    win_cause = '0;
    win_nmi   = 1'b0;
    if (nmi_pend) begin
      win_valid = 1'b1;
      win_cause = CAUSE_NMI;
      win_nmi   = 1'b1;
    end else if (tmr_pend && en_tmr_i && gie_i) begin
      win_valid = 1'b1;
      win_cause = CAUSE_TMR;
    end else begin
      for (int k = N_IRQ - 1; k >= 0; k--) begin
        if (ext_q[k]) begin
          win_valid = 1'b1;
          win_cause = 5'(16 + k);
        end
      end
    end
  end

  // A returning handler's mret beats a same-cycle NMI so we never preempt a finished handler.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cause_q     <= '0;
      nmi_q       <= 1'b0;
      nmi_active  <= 1'b0;
      saved_cause <= '0;
      saved_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state   <= ST_REQ;
            cause_q <= win_cause;
            nmi_q   <= win_nmi;
          end
        end
        ST_REQ: begin
          if (ack_i) begin
            state <= ST_SERVICE;
            if (nmi_q)
              nmi_active <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (mret_i) begin
            if (nmi_active && saved_valid) begin
              nmi_active  <= 1'b0;
              saved_valid <= 1'b0;
              cause_q     <= saved_cause;
              nmi_q       <= 1'b0;
            end else begin
              nmi_active <= 1'b0;
              nmi_q      <= 1'b0;
              state      <= ST_IDLE;
            end
          end else if (nmi_pend && !nmi_active) begin
            state       <= ST_REQ;
            saved_cause <= cause_q;
            saved_valid <= 1'b1;
            cause_q     <= CAUSE_NMI;
            nmi_q       <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_o     = (state == ST_REQ);
  assign busy_o    = (state == ST_SERVICE);
  assign cause_o   = cause_q;
  assign nmi_o     = nmi_q;
  assign pending_o = pend;
  assign tmr_cnt_o = cnt;

endmodule
